memory_stream_reader: RTL and testbench

Sequential read-out engine that sits directly downstream of the dual-port registered-output memory on its B port. On a start command it reads `count` consecutive words from `base_addr`, absorbs the memory's fixed one-cycle read latency, and presents the words as a valid/ready stream with full backpressure. It is used to dump instruction/scratch memories to the host-side streaming path.

---
 rtl/memory_stream_reader_pkg.sv | 17 +
 rtl/memory_stream_reader_stream_fifo2.sv | 85 ++++++++
 rtl/memory_stream_reader.sv | 131 +++++++++++++
 tb/tb_memory_stream_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stream_reader_pkg.sv
// Shared definitions for the memory streaming engines (reader and the
// companion write-side loader).
//   state_e    : engine state (IDLE / RUN / DRAIN)
//   FIFO_DEPTH : entries in the response/output buffer
//   OCC_WIDTH  : width needed to encode an occupancy of 0..FIFO_DEPTH
package memory_stream_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int FIFO_DEPTH = 2;
   localparam int OCC_WIDTH  = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/memory_stream_reader_stream_fifo2.sv
// stream_fifo2: 2-entry register FIFO. Entry 0 is always the head, so the
// head outputs come straight from a register.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write one entry (ignored when full and not popping)
//   pop_i         : remove the head entry
//   clear_i       : empty the FIFO; dominates push and pop
//   head_o        : head entry data
//   valid_o       : FIFO not empty
//   occ_o         : current occupancy (0..2)
module stream_fifo2
   import memory_stream_reader_pkg::*;
#(
   parameter int WIDTH = 17
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic [WIDTH-1:0]     data_i,
   input  logic                 pop_i,
   input  logic                 clear_i,
   output logic [WIDTH-1:0]     head_o,
   output logic                 valid_o,
   output logic [OCC_WIDTH-1:0] occ_o
);

   logic [WIDTH-1:0]     e0_q, e0_d;
   logic [WIDTH-1:0]     e1_q, e1_d;
   logic [OCC_WIDTH-1:0] occ_q, occ_d;

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      occ_d = occ_q;
      if (clear_i) begin
         occ_d = '0;
      end else begin
         case (occ_q)
            OCC_WIDTH'(0): begin
               if (push_i) begin
                  e0_d  = data_i;
                  occ_d = OCC_WIDTH'(1);
               end
            end
            OCC_WIDTH'(1): begin
               if (push_i && pop_i) begin
                  e0_d = data_i;
               end else if (push_i) begin
                  e1_d  = data_i;
                  occ_d = OCC_WIDTH'(2);
               end else if (pop_i) begin
                  occ_d = OCC_WIDTH'(0);
               end
            end
            default: begin
               // Full: the second entry shifts into the head on a pop.
               if (pop_i) begin
                  e0_d = e1_q;
                  if (push_i) begin
                     e1_d = data_i;
                  end else begin
                     occ_d = OCC_WIDTH'(1);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         e0_q  <= '0;
         e1_q  <= '0;
         occ_q <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         occ_q <= occ_d;
      end
   end

   assign head_o  = e0_q;
   assign valid_o = (occ_q != '0);
   assign occ_o   = occ_q;

endmodule

// File: rtl/memory_stream_reader.sv
// memory_stream_reader: reads `count` consecutive words starting at
// `base_addr` from a registered-output memory port and presents them as a
// valid/ready stream with full backpressure.
//   clock, reset_n        : clock, asynchronous active-low reset
//   start/base_addr/count : command, accepted only when idle
//   abort                 : cancel the active transfer
//   busy, done            : transfer active, one-cycle end pulse
//   mem_addr/mem_we       : memory read port address / write enable (0)
//   mem_rdata             : memory data, one cycle after mem_addr
//   m_valid/m_ready/m_data/m_last : output stream
module memory_stream_reader
   import memory_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 11,
   parameter int COUNT_WIDTH   = ADDRESS_WIDTH + 1
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [COUNT_WIDTH-1:0]   count,
   input  logic                     abort,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic                     mem_we,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DATA_WIDTH-1:0]    m_data,
   output logic                     m_last
);

   state_e                   state_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [COUNT_WIDTH-1:0]   remaining_q;
   logic                     inflight_q;
   logic                     inflight_last_q;
   logic                     done_q;

   logic [OCC_WIDTH-1:0]     occ;
   logic [DATA_WIDTH:0]      head;
   logic                     pop;
   logic                     issue;
   logic                     clear;
   logic                     drained;
   logic [OCC_WIDTH:0]       pending;

   assign pop     = m_valid & m_ready;
   assign clear   = abort & (state_q != ST_IDLE);
   // Words already committed to the buffer: stored plus the one in flight.
   assign pending = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight_q};
   // Credit rule: never commit more words than the buffer can hold, counting
   // the slot freed by a pop in this same cycle.
   assign issue   = (state_q == ST_RUN) && !abort && (remaining_q != '0) &&
                    (pending < ((OCC_WIDTH + 1)'(FIFO_DEPTH) + {{OCC_WIDTH{1'b0}}, pop}));
   // Everything delivered once this cycle's pop completes.
   assign drained = (pending == {{OCC_WIDTH{1'b0}}, pop});

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         addr_q          <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         done_q          <= 1'b0;
         inflight_q      <= issue;
         inflight_last_q <= issue && (remaining_q == COUNT_WIDTH'(1));
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q      <= base_addr;
                  remaining_q <= count;
                  if (count == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end else if (issue) begin
                  addr_q      <= addr_q + ADDRESS_WIDTH'(1);
                  remaining_q <= remaining_q - COUNT_WIDTH'(1);
                  if (remaining_q == COUNT_WIDTH'(1)) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (abort || drained) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Response capture is unconditional on inflight; the credit rule
   // guarantees a free slot.
   stream_fifo2 #(
      .WIDTH(DATA_WIDTH + 1)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset_n),
      .push_i  (inflight_q),
      .data_i  ({inflight_last_q, mem_rdata}),
      .pop_i   (pop),
      .clear_i (clear),
      .head_o  (head),
      .valid_o (m_valid),
      .occ_o   (occ)
   );

   assign m_data   = head[DATA_WIDTH-1:0];
   assign m_last   = head[DATA_WIDTH];
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign mem_addr = addr_q;
   assign mem_we   = 1'b0;

endmodule

// File: tb/tb_memory_stream_reader.sv
// Directed testbench for memory_stream_reader against a registered-output
// memory model preloaded with word[i] = i.
module tb_memory_stream_reader;

   localparam int DW = 16;
   localparam int AW = 11;
   localparam int CW = AW + 1;
   localparam int DEPTH = 1 << AW;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [CW-1:0] count = '0;
   logic          abort = 1'b0;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_rdata = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;

   logic [DW-1:0] mem [0:DEPTH-1];

   int checks = 0;
   int failures = 0;
   int got_data[$];
   int got_last[$];
   bit done_seen;
   bit ovf;

   always #5 clock = ~clock;

   always @(posedge clock) mem_rdata <= mem[mem_addr];

   memory_stream_reader #(
      .DATA_WIDTH(DW),
      .ADDRESS_WIDTH(AW),
      .COUNT_WIDTH(CW)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

   task automatic check_eq(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Drives a command in the current cycle (cycle 0); returns in cycle 1.
   task automatic do_start(input int base, input int cnt);
      start     = 1'b1;
      base_addr = AW'(base);
      count     = CW'(cnt);
      tick();
      start     = 1'b0;
   endtask

   // Collects beats until done, with m_ready either held high or following
   // the pattern 1,0,0,1,0,1 repeating. Also tracks reads issued minus beats
   // delivered, which must never exceed the buffer depth.
   task automatic collect(input int base, input bit toggle);
      int delivered;
      logic [AW-1:0] diff;
      logic [5:0] pat;
      pat = 6'b101001;
      delivered = 0;
      done_seen = 1'b0;
      ovf = 1'b0;
      got_data.delete();
      got_last.delete();
      for (int k = 0; k < 300 && !done_seen; k++) begin
         m_ready = toggle ? pat[k % 6] : 1'b1;
         diff = mem_addr - AW'(base);
         if (int'(diff) - delivered > 2) ovf = 1'b1;
         if (done) begin
            done_seen = 1'b1;
         end else if (m_valid && m_ready) begin
            got_data.push_back(int'(m_data));
            got_last.push_back(int'(m_last));
            delivered++;
         end
         tick();
      end
      m_ready = 1'b1;
      check_eq("done_seen", int'(done_seen), 1);
   endtask

   task automatic expect_beats(input int first, input int n);
      check_eq("beat_count", got_data.size(), n);
      check_eq("no_overflow", int'(ovf), 0);
      for (int i = 0; i < n && i < got_data.size(); i++) begin
         check_eq("beat_data", got_data[i], (first + i) % DEPTH);
         check_eq("beat_last", got_last[i], (i == n - 1) ? 1 : 0);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_busy"}, int'(busy), 0);
      check_eq({tag, "_done"}, int'(done), 0);
      check_eq({tag, "_valid"}, int'(m_valid), 0);
      check_eq({tag, "_last"}, int'(m_last), 0);
      check_eq({tag, "_data"}, int'(m_data), 0);
      check_eq({tag, "_addr"}, int'(mem_addr), 0);
      check_eq({tag, "_we"}, int'(mem_we), 0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

      // Reset values, during and after reset.
      tick();
      tick();
      check_idle_outputs("rst");
      reset_n = 1'b1;
      tick();
      check_idle_outputs("post_rst");

      // base=5, count=4, ready high: exact cycle timing.
      m_ready = 1'b1;
      do_start(5, 4);
      check_eq("c1_busy", int'(busy), 1);
      check_eq("c1_addr", int'(mem_addr), 5);
      tick();
      check_eq("c2_valid", int'(m_valid), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("t1_valid", int'(m_valid), 1);
         check_eq("t1_data", int'(m_data), 5 + i);
         check_eq("t1_last", int'(m_last), (i == 3) ? 1 : 0);
         check_eq("t1_done_early", int'(done), 0);
      end
      tick();
      check_eq("c7_done", int'(done), 1);
      check_eq("c7_busy", int'(busy), 0);
      check_eq("c7_valid", int'(m_valid), 0);
      tick();
      check_eq("c8_done", int'(done), 0);

      // Address wrap.
      do_start(2046, 4);
      collect(2046, 1'b0);
      expect_beats(2046, 4);

      // Backpressure with toggling ready.
      do_start(40, 6);
      collect(40, 1'b1);
      expect_beats(40, 6);

      // count = 0: done at cycle 1, busy never rises.
      do_start(9, 0);
      check_eq("z_done", int'(done), 1);
      check_eq("z_busy", int'(busy), 0);
      check_eq("z_valid", int'(m_valid), 0);
      tick();
      check_eq("z_done_after", int'(done), 0);

      // Second start while busy is ignored.
      do_start(10, 3);
      start = 1'b1;
      base_addr = AW'(100);
      count = CW'(3);
      tick();
      start = 1'b0;
      collect(10, 1'b0);
      expect_beats(10, 3);
      tick();
      check_eq("ign_busy", int'(busy), 0);
      check_eq("ign_valid", int'(m_valid), 0);

      // start and abort together in IDLE: start wins.
      abort = 1'b1;
      do_start(50, 2);
      abort = 1'b0;
      collect(50, 1'b0);
      expect_beats(50, 2);

      // Abort after three delivered beats.
      do_start(20, 8);
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("ab_valid", int'(m_valid), 1);
         check_eq("ab_data", int'(m_data), 20 + i);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("ab_valid_after", int'(m_valid), 0);
      check_eq("ab_done", int'(done), 1);
      check_eq("ab_busy", int'(busy), 0);
      tick();
      check_eq("ab_valid_late", int'(m_valid), 0);
      check_eq("ab_done_after", int'(done), 0);
      do_start(0, 1);
      collect(0, 1'b0);
      expect_beats(0, 1);

      // Asynchronous reset mid-transfer.
      do_start(100, 8);
      tick();
      tick();
      tick();
      reset_n = 1'b0;
      #2;
      check_idle_outputs("arst");
      reset_n = 1'b1;
      tick();
      check_eq("arst_done1", int'(done), 0);
      check_eq("arst_busy1", int'(busy), 0);
      tick();
      check_eq("arst_done2", int'(done), 0);
      do_start(7, 3);
      collect(7, 1'b0);
      expect_beats(7, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
